// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the ID/EX register and the iterative
// multiply/divide unit.
interface ex_muldiv_if #(
    parameter int unsigned WordSize = 32
);
    logic                start;
    logic [2:0]          funct3;
    logic [WordSize-1:0] a;
    logic [WordSize-1:0] b;
    logic [4:0]          rdn_in;
    logic                flush;
    logic                stall;
    logic                busy;
    logic                done;
    logic [WordSize-1:0] result;
    logic [4:0]          rdn;

    modport master (
        output start, funct3, a, b, rdn_in, flush,
        input  stall, busy, done, result, rdn
    );

    modport slave (
        input  start, funct3, a, b, rdn_in, flush,
        output stall, busy, done, result, rdn
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fix-up at the end.
module ex_muldiv #(
    parameter int unsigned WordSize = 32
) (
    input  logic     clk,
    input  logic     rstn,
    ex_muldiv_if.slave mdu
);
    localparam int unsigned W    = WordSize;
    localparam int unsigned CntW = $clog2(WordSize);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    m_q, m_d;
    logic            is_mul_q, is_mul_d;
    logic            sel_hi_q, sel_hi_d;
    logic            neg_q, neg_d;
    logic [4:0]      rdn_lat_q, rdn_lat_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    result_q, result_d;
    logic [4:0]      rdn_q, rdn_d;

    // Operand decode for the request presented in IDLE
    logic         op_mul, a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         div0, ovf, special;
    logic [W-1:0] special_val;

    always_comb begin
        op_mul   = ~mdu.funct3[2];
        a_signed = (mdu.funct3 == 3'b001) || (mdu.funct3 == 3'b010) ||
                   (mdu.funct3 == 3'b100) || (mdu.funct3 == 3'b110);
        b_signed = (mdu.funct3 == 3'b001) || (mdu.funct3 == 3'b100) ||
                   (mdu.funct3 == 3'b110);
        a_neg    = a_signed & mdu.a[W-1];
        b_neg    = b_signed & mdu.b[W-1];
        a_mag    = a_neg ? (W'(0) - mdu.a) : mdu.a;
        b_mag    = b_neg ? (W'(0) - mdu.b) : mdu.b;
        div0     = mdu.funct3[2] & (mdu.b == '0);
        ovf      = mdu.funct3[2] & ~mdu.funct3[0] &
                   (mdu.a == {1'b1, {(W-1){1'b0}}}) & (mdu.b == {W{1'b1}});
        special  = div0 | ovf;
        if (div0) special_val = mdu.funct3[1] ? mdu.a : {W{1'b1}};
        else      special_val = mdu.funct3[1] ? '0 : mdu.a;
    end

    // One iteration of each algorithm; acc holds {hi, lo}
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
    end

    // Sign correction: multiply negates the full product, divide one word
    logic [2*W-1:0] mul_full;
    logic [W-1:0]   div_word, fix_res;

    always_comb begin
        mul_full = neg_q ? ((2*W)'(0) - acc_q) : acc_q;
        div_word = sel_hi_q ? acc_q[2*W-1:W] : acc_q[W-1:0];
        if (neg_q) div_word = W'(0) - div_word;
        if (is_mul_q) fix_res = sel_hi_q ? mul_full[2*W-1:W] : mul_full[W-1:0];
        else          fix_res = div_word;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        is_mul_d  = is_mul_q;
        sel_hi_d  = sel_hi_q;
        neg_d     = neg_q;
        rdn_lat_d = rdn_lat_q;
        done_d    = 1'b0;
        result_d  = result_q;
        rdn_d     = rdn_q;

        case (state_q)
            IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    rdn_lat_d = mdu.rdn_in;
                    cnt_d     = '0;
                    if (special) begin
                        state_d  = FIX;
                        is_mul_d = 1'b0;
                        sel_hi_d = 1'b0;
                        neg_d    = 1'b0;
                        acc_d    = {{W{1'b0}}, special_val};
                    end else begin
                        state_d  = CALC;
                        is_mul_d = op_mul;
                        sel_hi_d = op_mul ? (mdu.funct3[1:0] != 2'b00) : mdu.funct3[1];
                        neg_d    = (!op_mul && mdu.funct3[1]) ? a_neg : (a_neg ^ b_neg);
                        m_d      = op_mul ? a_mag : b_mag;
                        acc_d    = {{W{1'b0}}, op_mul ? b_mag : a_mag};
                    end
                end
            end
            CALC: begin
                acc_d = is_mul_q ? mul_next : div_next;
                cnt_d = CntW'(cnt_q + 1'b1);
                if (cnt_q == CntW'(W - 1)) state_d = FIX;
            end
            FIX: begin
                done_d   = 1'b1;
                result_d = fix_res;
                rdn_d    = rdn_lat_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (mdu.flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            rdn_d    = rdn_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            is_mul_q  <= 1'b0;
            sel_hi_q  <= 1'b0;
            neg_q     <= 1'b0;
            rdn_lat_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            rdn_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            is_mul_q  <= is_mul_d;
            sel_hi_q  <= sel_hi_d;
            neg_q     <= neg_d;
            rdn_lat_q <= rdn_lat_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            rdn_q     <= rdn_d;
        end
    end

    // Stall is forced low while reset is held so upstream never freezes on it
    assign mdu.stall  = rstn & (((state_q == IDLE) & mdu.start & ~mdu.flush) |
                                (state_q == CALC));
    assign mdu.busy   = busy_q;
    assign mdu.done   = done_q;
    assign mdu.result = result_q;
    assign mdu.rdn    = rdn_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: multiply, divide, special cases, flush,
// back-to-back requests and reset during an operation.
module tb_ex_muldiv;
    localparam int unsigned W = 32;

    logic clk;
    logic rstn;
    int   vectors;
    int   errors;

    ex_muldiv_if #(.WordSize(W)) mdu ();

    ex_muldiv #(.WordSize(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .mdu  (mdu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one request and follow it to its done pulse (bounded)
    task automatic do_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd, output logic [W-1:0] res, output logic [4:0] rdo,
                         output int stall_n, output int lat, output logic done_after);
        stall_n    = 0;
        lat        = -1;
        res        = '0;
        rdo        = '0;
        done_after = 1'bx;
        @(negedge clk);
        mdu.funct3 = f3;
        mdu.a      = a;
        mdu.b      = b;
        mdu.rdn_in = rd;
        mdu.start  = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (mdu.stall) stall_n++;
            if (mdu.done) begin
                lat = i;
                res = mdu.result;
                rdo = mdu.rdn;
                break;
            end
            @(negedge clk);
            mdu.start = 1'b0;
            #1;
        end
        mdu.start = 1'b0;
        @(negedge clk);
        #1;
        done_after = mdu.done;
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        mdu.start  = 1'b1;
        mdu.flush  = 1'b0;
        mdu.funct3 = 3'b000;
        mdu.a      = 32'h0000_0005;
        mdu.b      = 32'h0000_0007;
        mdu.rdn_in = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors += 5;
        if (mdu.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mdu.busy); end
        if (mdu.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", mdu.done); end
        if (mdu.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", mdu.result); end
        if (mdu.rdn !== 5'd0) begin errors++; $display("FAIL reset_rdn got=%0d exp=0", mdu.rdn); end
        if (mdu.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", mdu.stall); end
        mdu.start = 1'b0;
        rstn      = 1'b1;
    endtask

    task automatic test_mul();
        logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b011};
        logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0002};
        logic [W-1:0] res;
        logic [4:0]   rdo;
        int           st, lat;
        logic         da;
        for (int i = 0; i < 3; i++) begin
            do_op(f3[i], 32'hFFFF_FFFF, 32'h0000_0003, 5'd5, res, rdo, st, lat, da);
            vectors += 5;
            if (res !== exp[i]) begin errors++; $display("FAIL mul_result f3=%b got=%h exp=%h", f3[i], res, exp[i]); end
            if (rdo !== 5'd5) begin errors++; $display("FAIL mul_rdn f3=%b got=%0d exp=5", f3[i], rdo); end
            if (st != 33) begin errors++; $display("FAIL mul_stall_cycles f3=%b got=%0d exp=33", f3[i], st); end
            if (lat != 34) begin errors++; $display("FAIL mul_latency f3=%b got=%0d exp=34", f3[i], lat); end
            if (da !== 1'b0) begin errors++; $display("FAIL mul_done_width f3=%b got=%b exp=0", f3[i], da); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
        logic [W-1:0] res;
        logic [4:0]   rdo;
        int           st, lat;
        logic         da;
        for (int i = 0; i < 4; i++) begin
            do_op(f3[i], 32'hFFFF_FFF9, 32'h0000_0002, 5'(10 + i), res, rdo, st, lat, da);
            vectors += 3;
            if (res !== exp[i]) begin errors++; $display("FAIL div_result f3=%b got=%h exp=%h", f3[i], res, exp[i]); end
            if (rdo !== 5'(10 + i)) begin errors++; $display("FAIL div_rdn f3=%b got=%0d exp=%0d", f3[i], rdo, 10 + i); end
            if (lat != 34) begin errors++; $display("FAIL div_latency f3=%b got=%0d exp=34", f3[i], lat); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] av  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_1234, 32'h0000_1234};
        logic [31:0] bv  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        logic [31:0] exp [4] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234};
        logic [W-1:0] res;
        logic [4:0]   rdo;
        int           st, lat;
        logic         da;
        for (int i = 0; i < 4; i++) begin
            do_op(f3[i], av[i], bv[i], 5'(20 + i), res, rdo, st, lat, da);
            vectors += 3;
            if (res !== exp[i]) begin errors++; $display("FAIL special_result f3=%b got=%h exp=%h", f3[i], res, exp[i]); end
            if (lat != 2) begin errors++; $display("FAIL special_latency f3=%b got=%0d exp=2", f3[i], lat); end
            if (da !== 1'b0) begin errors++; $display("FAIL special_done_width f3=%b got=%b exp=0", f3[i], da); end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] res;
        logic [4:0]   rdo;
        int           st, lat, done_seen;
        logic         da;
        done_seen = 0;
        @(negedge clk);
        mdu.funct3 = 3'b100;
        mdu.a      = 32'd1000;
        mdu.b      = 32'd7;
        mdu.rdn_in = 5'd9;
        mdu.start  = 1'b1;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mdu.done) done_seen++;
        end
        mdu.flush = 1'b1;
        @(negedge clk);
        mdu.flush = 1'b0;
        #1;
        vectors += 2;
        if (mdu.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", mdu.busy); end
        if (mdu.result !== 32'h0000_1234) begin errors++; $display("FAIL flush_result_kept got=%h exp=00001234", mdu.result); end
        repeat (40) begin
            @(negedge clk);
            if (mdu.done) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin errors++; $display("FAIL flush_no_done got=%0d pulses exp=0", done_seen); end
        do_op(3'b000, 32'd6, 32'd7, 5'd17, res, rdo, st, lat, da);
        vectors += 2;
        if (res !== 32'd42) begin errors++; $display("FAIL flush_then_mul got=%h exp=0000002a", res); end
        if (rdo !== 5'd17) begin errors++; $display("FAIL flush_then_mul_rdn got=%0d exp=17", rdo); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r [2];
        logic [4:0]   d [2];
        int           t [2];
        int           n;
        logic         switched;
        n        = 0;
        switched = 1'b0;
        @(negedge clk);
        mdu.funct3 = 3'b000;
        mdu.a      = 32'd3;
        mdu.b      = 32'd5;
        mdu.rdn_in = 5'd7;
        mdu.start  = 1'b1;
        #1;
        for (int i = 0; i < 200 && n < 2; i++) begin
            if (mdu.done) begin
                r[n] = mdu.result;
                d[n] = mdu.rdn;
                t[n] = i;
                n++;
            end
            if (!mdu.stall && !switched) begin
                mdu.funct3 = 3'b101;
                mdu.a      = 32'd100;
                mdu.b      = 32'd9;
                mdu.rdn_in = 5'd8;
                switched   = 1'b1;
            end
            if (n < 2) begin
                @(negedge clk);
                #1;
            end
        end
        mdu.start = 1'b0;
        vectors++;
        if (n != 2) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d exp=2", n);
        end else begin
            vectors += 5;
            if (r[0] !== 32'd15) begin errors++; $display("FAIL b2b_result0 got=%h exp=0000000f", r[0]); end
            if (d[0] !== 5'd7) begin errors++; $display("FAIL b2b_rdn0 got=%0d exp=7", d[0]); end
            if (r[1] !== 32'd11) begin errors++; $display("FAIL b2b_result1 got=%h exp=0000000b", r[1]); end
            if (d[1] !== 5'd8) begin errors++; $display("FAIL b2b_rdn1 got=%0d exp=8", d[1]); end
            if (t[1] - t[0] != 34) begin errors++; $display("FAIL b2b_gap got=%0d exp=34", t[1] - t[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        mdu.funct3 = 3'b000;
        mdu.a      = 32'd6;
        mdu.b      = 32'd7;
        mdu.rdn_in = 5'd4;
        mdu.start  = 1'b1;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        vectors += 5;
        if (mdu.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", mdu.busy); end
        if (mdu.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", mdu.done); end
        if (mdu.result !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", mdu.result); end
        if (mdu.rdn !== 5'd0) begin errors++; $display("FAIL rstmid_rdn got=%0d exp=0", mdu.rdn); end
        if (mdu.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", mdu.stall); end
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (mdu.done) done_seen++;
        end
        vectors += 2;
        if (done_seen != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", done_seen); end
        if (mdu.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after got=%b exp=0", mdu.busy); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
